// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath widths, major opcodes, load funct3 codes
// and the writeback-source decode used by the writeback stage.
package rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_COUNT = 32;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OPIMM  = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_SRC_NONE,
      WB_SRC_LOAD,
      WB_SRC_LINK,
      WB_SRC_ALU
   } wb_src_e;

   // STORE, BRANCH, FENCE, SYSTEM and the all-zero bubble fall out as NONE.
   function automatic wb_src_e wb_src_of(input logic [6:0] opcode);
      wb_src_e src;
      src = WB_SRC_NONE;
      case (opcode)
         OPC_LOAD:                               src = WB_SRC_LOAD;
         OPC_JAL, OPC_JALR:                      src = WB_SRC_LINK;
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC:  src = WB_SRC_ALU;
         default:                                src = WB_SRC_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/wb_regfile_load_extend.sv
// Load-value extraction: selects byte/halfword from an aligned memory word
// and sign- or zero-extends it according to the load funct3.
module load_extend
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = '0;
      case (addr)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
   end

   // addr[0] is ignored for halfwords; misalignment is trapped upstream.
   assign half_sel = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      value = word;
      case (funct3)
         F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  value = {24'h0, byte_sel};
         F3_LH:   value = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  value = {16'h0, half_sel};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 architectural register file and 64-bit instret.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     data_mem_i,
   input  logic [31:0]     data_i,
   input  logic [31:0]     pc_next_i,
   input  logic [4:0]      wbaddr_i,
   input  logic [31:0]     instr_i,
   input  logic [4:0]      raddr1_i,
   input  logic [4:0]      raddr2_i,
   output logic [31:0]     rdata1_o,
   output logic [31:0]     rdata2_o,
   output logic            wb_we_o,
   output logic [4:0]      wb_addr_o,
   output logic [31:0]     wb_data_o,
   output logic [63:0]     instret_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   wb_src_e         wb_src;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] wb_data;
   logic            wb_we;

   logic [XLEN-1:0] rf_q [REG_COUNT];
   logic [63:0]     instret_q, instret_d;

   logic            unused_instr_bits;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

   load_extend u_load_extend (
      .word   (data_mem_i),
      .addr   (data_i[1:0]),
      .funct3 (funct3),
      .value  (load_val)
   );

   always_comb begin
      wb_src  = wb_src_of(opcode);
      wb_data = '0;
      case (wb_src)
         WB_SRC_LOAD: wb_data = load_val;
         WB_SRC_LINK: wb_data = pc_next_i;
         WB_SRC_ALU:  wb_data = data_i;
         default:     wb_data = '0;
      endcase
      wb_we = (wb_src != WB_SRC_NONE) && (wbaddr_i != '0);
   end

   assign wb_we_o   = wb_we;
   assign wb_addr_o = wbaddr_i;
   assign wb_data_o = wb_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_we) begin
         rf_q[wbaddr_i] <= wb_data;
      end
   end

   always_comb begin
      instret_d = instret_q;
      if (instr_i != '0) begin
         instret_d = instret_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret_o = instret_q;

   // Write-through is suppressed during reset so reads show stored state only.
   always_comb begin
      rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
      rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
      if (!reset && wb_we && (raddr1_i == wbaddr_i)) begin
         rdata1_o = wb_data;
      end
      if (!reset && wb_we && (raddr2_i == wbaddr_i)) begin
         rdata2_o = wb_data;
      end
`endif
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a reference model predicts each cycle's
// outputs, which are queued at drive time and compared at the next negedge.
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic [31:0] data_mem_i, data_i, pc_next_i, instr_i;
   logic [4:0]  wbaddr_i, raddr1_i, raddr2_i;
   logic [31:0] rdata1_o, rdata2_o, wb_data_o;
   logic        wb_we_o;
   logic [4:0]  wb_addr_o;
   logic [63:0] instret_o;

   wb_regfile u_dut (
      .clk        (clk),
      .reset      (reset),
      .data_mem_i (data_mem_i),
      .data_i     (data_i),
      .pc_next_i  (pc_next_i),
      .wbaddr_i   (wbaddr_i),
      .instr_i    (instr_i),
      .raddr1_i   (raddr1_i),
      .raddr2_i   (raddr2_i),
      .rdata1_o   (rdata1_o),
      .rdata2_o   (rdata2_o),
      .wb_we_o    (wb_we_o),
      .wb_addr_o  (wb_addr_o),
      .wb_data_o  (wb_data_o),
      .instret_o  (instret_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        we;
      logic [4:0]  wba;
      logic        chk_wb;
      logic [31:0] wbd;
      logic [63:0] instret;
   } exp_t;

   exp_t        exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] ref_rf [32];
   logic [63:0] ref_instret;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
      return {17'h0, f3, 5'h0, opc};
   endfunction

   // Independent writeback model: shift-based extraction, literal opcodes.
   task automatic model_wb(input logic [31:0] instr, input logic [31:0] dat,
                           input logic [31:0] mem, input logic [31:0] pc,
                           output logic wr, output logic [31:0] val);
      logic [31:0] b, h;
      b = mem >> {dat[1:0], 3'b000};
      h = mem >> {dat[1], 4'b0000};
      wr  = 1'b0;
      val = 32'h0;
      case (instr[6:0])
         7'h03: begin
            wr = 1'b1;
            case (instr[14:12])
               3'd0:    val = {{24{b[7]}}, b[7:0]};
               3'd4:    val = {24'h0, b[7:0]};
               3'd1:    val = {{16{h[15]}}, h[15:0]};
               3'd5:    val = {16'h0, h[15:0]};
               default: val = mem;
            endcase
         end
         7'h6F, 7'h67:             begin wr = 1'b1; val = pc;  end
         7'h33, 7'h13, 7'h37, 7'h17: begin wr = 1'b1; val = dat; end
         default: wr = 1'b0;
      endcase
   endtask

   function automatic logic [31:0] rd_model(input logic [4:0] r, input logic rst,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wbd);
      logic [31:0] v;
      v = (r == 5'd0) ? 32'h0 : ref_rf[r];
`ifdef REGFILE_BYPASS_EN
      if (!rst && we && (r == wa)) v = wbd;
`endif
      return v;
   endfunction

   task automatic step(input string tag, input logic rst, input logic [31:0] instr,
                       input logic [4:0] wa, input logic [31:0] dat,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
      exp_t        e;
      logic        wr;
      logic [31:0] val;
      reset = rst; instr_i = instr; wbaddr_i = wa; data_i = dat;
      data_mem_i = mem; pc_next_i = pc; raddr1_i = r1; raddr2_i = r2;
      model_wb(instr, dat, mem, pc, wr, val);
      e.we      = wr && (wa != 5'd0);
      e.wba     = wa;
      e.chk_wb  = wr;
      e.wbd     = val;
      e.rd1     = rd_model(r1, rst, e.we, wa, val);
      e.rd2     = rd_model(r2, rst, e.we, wa, val);
      e.instret = ref_instret;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
         ref_instret = 64'h0;
      end else begin
         if (e.we) ref_rf[wa] = val;
         if (instr != 32'h0) ref_instret = ref_instret + 64'd1;
      end
      #1;
   endtask

   always @(negedge clk) begin : scoreboard
      exp_t  e;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_val({t, ".rdata1"},  {32'h0, rdata1_o}, {32'h0, e.rd1});
         check_val({t, ".rdata2"},  {32'h0, rdata2_o}, {32'h0, e.rd2});
         check_val({t, ".wb_we"},   {63'h0, wb_we_o},  {63'h0, e.we});
         check_val({t, ".wb_addr"}, {59'h0, wb_addr_o}, {59'h0, e.wba});
         if (e.chk_wb) check_val({t, ".wb_data"}, {32'h0, wb_data_o}, {32'h0, e.wbd});
         check_val({t, ".instret"}, instret_o, e.instret);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] ADDI   = 32'h00500093;
   localparam logic [31:0] BUBBLE = 32'h0;

   initial begin : stim
      logic [6:0] opcs [9];
      opcs = '{7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63};
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      ref_instret = 64'h0;

      reset = 1'b1; instr_i = '0; wbaddr_i = '0; data_i = '0;
      data_mem_i = '0; pc_next_i = '0; raddr1_i = '0; raddr2_i = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 1; i < 32; i++)
         step("reset_read", 1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(32 - i));

      step("addi_wr",  1'b0, ADDI,   5'd1, 32'd5, 32'h0, 32'h0, 5'd0, 5'd0);
      step("addi_rd",  1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0);
      step("instret1", 1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd1);

      step("lb",   1'b0, mk(7'h03, 3'd0), 5'd3, 32'h1002, 32'h80FF7F01, 32'h0, 5'd0, 5'd0);
      step("lb_rd",  1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
      step("lbu",  1'b0, mk(7'h03, 3'd4), 5'd4, 32'h1002, 32'h80FF7F01, 32'h0, 5'd3, 5'd0);
      step("lh",   1'b0, mk(7'h03, 3'd1), 5'd6, 32'h1002, 32'h80FF7F01, 32'h0, 5'd4, 5'd0);
      step("lhu0", 1'b0, mk(7'h03, 3'd5), 5'd8, 32'h1000, 32'h80FF7F01, 32'h0, 5'd6, 5'd4);
      step("lb3",  1'b0, mk(7'h03, 3'd0), 5'd9, 32'h1003, 32'h80FF7F01, 32'h0, 5'd8, 5'd0);
      step("lw",   1'b0, mk(7'h03, 3'd2), 5'd10, 32'h1003, 32'h80FF7F01, 32'h0, 5'd9, 5'd0);
      step("lf3_7", 1'b0, mk(7'h03, 3'd7), 5'd11, 32'h1001, 32'hCAFEBABE, 32'h0, 5'd10, 5'd0);

      step("jal",    1'b0, mk(7'h6F, 3'd0), 5'd1, 32'h55, 32'h0, 32'h104, 5'd11, 5'd0);
      step("jal_rd", 1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0);
      step("wr_x0",  1'b0, ADDI, 5'd0, 32'hDEAD, 32'h0, 32'h0, 5'd0, 5'd0);
      step("x0_rd",  1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd1);

      step("x5_old",  1'b0, ADDI, 5'd5, 32'h10, 32'h0, 32'h0, 5'd0, 5'd0);
      step("x5_same", 1'b0, ADDI, 5'd5, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd5);
      step("x5_next", 1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);

      for (int i = 0; i < 4; i++) begin
         step("store",  1'b0, mk(7'h23, 3'd2), 5'd12, 32'h77, 32'h0, 32'h0, 5'd12, 5'd5);
         step("bubble", 1'b0, BUBBLE, 5'd13, 32'h88, 32'h0, 32'h0, 5'd12, 5'd13);
      end

      for (int i = 0; i < 40; i++) begin
         logic [4:0] wa, r1;
         wa = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
         step("rand", 1'b0, mk(opcs[$urandom_range(0, 8)], 3'($urandom_range(0, 7))),
              wa, $urandom, $urandom, $urandom, r1, 5'($urandom_range(0, 31)));
      end

      step("pre_rst", 1'b0, ADDI, 5'd1, 32'h99, 32'h0, 32'h0, 5'd1, 5'd7);
      step("rst_wr",  1'b1, ADDI, 5'd7, 32'h55, 32'h0, 32'h0, 5'd7, 5'd1);
      step("post_rst", 1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd1);
      step("idle",     1'b0, BUBBLE, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd3);

      @(negedge clk);
      #1;
      check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
